// File: rtl/sub_tc16_serial_pkg.sv
// sub_tc16_serial_pkg
// Shared definitions for the nibble-serial subtractor: FSM state encoding,
// nibble width and the nibble-counter width helper.
package sub_tc16_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int NIBBLE_W = 4;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) begin
        r = r + 1;
      end
    end
    return r;
  endfunction

  // Nibble counter width for a W-bit operand; never narrower than one bit.
  function automatic int cnt_w(input int w);
    int c;
    c = clog2(w / NIBBLE_W);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/sub_tc16_serial_if.sv
// sub_tc16_serial_if
// Operand/result handshake bundle for the serial subtractor.
//   in_valid/in_ready/a/b        : operand channel (master -> slave)
//   out_valid/out_ready/d/flags  : result channel (slave -> master)
// The master modport is the producer/consumer side, the slave modport is the
// subtractor itself.
interface sub_tc16_serial_if #(
  parameter int W = 16
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         borrow;
  logic         ovf;
  logic         zero;
  logic         neg;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, d, borrow, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, d, borrow, ovf, zero, neg
  );

endinterface

// File: rtl/sub_tc16_serial_sub4_slice.sv
// sub_tc16_serial_sub4_slice
// Combinational 4-bit carry-lookahead nibble.
//   x_i, y_i : nibble operands
//   c_in_i   : carry in
//   s_o      : nibble sum
//   c_out_o  : carry out
//   gg_o     : group generate (nibble produces a carry regardless of c_in)
//   gp_o     : group propagate (nibble passes c_in straight through)
module sub_tc16_serial_sub4_slice
  import sub_tc16_serial_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x_i,
  input  logic [NIBBLE_W-1:0] y_i,
  input  logic                c_in_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                c_out_o,
  output logic                gg_o,
  output logic                gp_o
);

  logic [NIBBLE_W-1:0] g_s;
  logic [NIBBLE_W-1:0] p_s;
  logic [NIBBLE_W-1:0] c_s;

  // Lookahead carries: every internal carry is a flat function of c_in.
  always_comb begin
    g_s     = x_i & y_i;
    p_s     = x_i ^ y_i;
    c_s[0]  = c_in_i;
    c_s[1]  = g_s[0] | (p_s[0] & c_in_i);
    c_s[2]  = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_in_i);
    c_s[3]  = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
            | (p_s[2] & p_s[1] & p_s[0] & c_in_i);
    gg_o    = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
            | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
    gp_o    = &p_s;
    c_out_o = gg_o | (gp_o & c_in_i);
    s_o     = p_s ^ c_s;
  end

endmodule

// File: rtl/sub_tc16_serial.sv
// sub_tc16_serial
// Nibble-serial two's-complement subtractor d = a - b, computed as a + ~b + 1
// one nibble per clock (LSB first) through a single lookahead slice.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of sub_tc16_serial_if (operands in, result out)
// Latency is W/4 cycles from acceptance to out_valid; every output is a
// register, so in_valid/out_ready never reach an output combinationally.
module sub_tc16_serial
  import sub_tc16_serial_pkg::*;
#(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst,
  sub_tc16_serial_if.slave bus
);

  localparam int N  = W / NIBBLE_W;
  localparam int CW = cnt_w(W);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [W-1:0]          a_q, a_d;
  logic [W-1:0]          nb_q, nb_d;
  logic [W-1:0]          d_q, d_d;
  logic                  carry_q, carry_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  borrow_q, borrow_d;
  logic                  ovf_q, ovf_d;
  logic                  zero_q, zero_d;
  logic                  neg_q, neg_d;

  logic [NIBBLE_W-1:0]   x_s, y_s, s_s;
  logic                  c_out_s, gg_s, gp_s;
  logic                  last_s;
  logic [W-1:0]          d_full_s;

  // Select the active nibble and form the result as it will look after this edge.
  always_comb begin
    x_s      = a_q[NIBBLE_W*int'(cnt_q) +: NIBBLE_W];
    y_s      = nb_q[NIBBLE_W*int'(cnt_q) +: NIBBLE_W];
    last_s   = (cnt_q == CW'(N - 1));
    d_full_s = d_q;
    d_full_s[NIBBLE_W*int'(cnt_q) +: NIBBLE_W] = s_s;
  end

  sub_tc16_serial_sub4_slice u_slice (
    .x_i     (x_s),
    .y_i     (y_s),
    .c_in_i  (carry_q),
    .s_o     (s_s),
    .c_out_o (c_out_s),
    .gg_o    (gg_s),
    .gp_o    (gp_s)
  );

  // Next-state, datapath and flag logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    nb_d     = nb_q;
    d_d      = d_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    case (state_q)
      IDLE: begin
        // in_ready_q is still low on the first cycle after reset release.
        if (bus.in_valid && in_ready_q) begin
          a_d     = bus.a;
          nb_d    = ~bus.b;
          carry_d = 1'b1;
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        d_d     = d_full_s;
        // Carry register is fed from the slice's group terms.
        carry_d = gg_s | (gp_s & carry_q);
        if (last_s) begin
          cnt_d    = {CW{1'b0}};
          borrow_d = ~c_out_s;
          // Sign of b is recovered from the stored inverted subtrahend.
          ovf_d    = (a_q[W-1] != ~nb_q[W-1]) && (d_full_s[W-1] != a_q[W-1]);
          zero_d   = (d_full_s == {W{1'b0}});
          neg_d    = d_full_s[W-1];
          state_d  = DONE;
        end else begin
          cnt_d    = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State, operand, result and handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      a_q         <= {W{1'b0}};
      nb_q        <= {W{1'b0}};
      d_q         <= {W{1'b0}};
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      nb_q        <= nb_d;
      d_q         <= d_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      borrow_q    <= borrow_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.d         = d_q;
  assign bus.borrow    = borrow_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;

endmodule

// File: tb/tb_sub_tc16_serial.sv
// tb_sub_tc16_serial
// Scoreboard bench: the driver pushes the reference result of every accepted
// operation; an independent monitor owns out_ready, pops on each result
// handshake and compares, and also checks latency, hold-under-backpressure,
// in_ready low while a result is pending, and spurious results.
module tb_sub_tc16_serial;

  localparam int W = 16;

  typedef struct {
    logic [15:0] d;
    logic        borrow;
    logic        ovf;
    logic        zero;
    logic        neg;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sub_tc16_serial_if #(.W(W)) bus ();

  sub_tc16_serial #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  int   hold_force = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int acc);
    exp_t e;
    int sa, sb, sd;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sd = sa - sb;
    e.d      = 16'((int'(a) - int'(b) + 65536) % 65536);
    e.borrow = (int'(a) < int'(b));
    e.ovf    = (sd > 32767) || (sd < -32768);
    e.zero   = (e.d == 16'h0000);
    e.neg    = (sd < -32768) ? 1'b0 : ((sd > 32767) ? 1'b1 : (sd < 0));
    e.acc    = acc;
    return e;
  endfunction

  // Present an operand pair, wait for acceptance; optionally churn the inputs
  // while the operation is in flight.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit push, input bit churn);
    int t;
    t = 0;
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    if (push) sb_q.push_back(model(a, b, cyc + 1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (churn) begin
      t = 0;
      while (t < 100) begin
        @(negedge clk);
        t++;
        if (bus.in_ready) begin
          bus.in_valid = 1'b0;
          break;
        end
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
      end
      if (!bus.in_ready) check("idle_return_timeout", 32'(bus.in_ready), 32'd1);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: drives out_ready, compares on each handshake.
  initial begin : monitor
    exp_t        e;
    bit          pv;
    int          wait_n;
    logic [19:0] held;
    pv = 1'b0;
    wait_n = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        bus.out_ready = 1'b0;
      end else if (!bus.out_valid) begin
        pv = 1'b0;
        bus.out_ready = (hold_force >= 0) ? 1'b0 : 1'($urandom_range(0, 1));
      end else begin
        check("in_ready_low_while_done", 32'(bus.in_ready), 32'd0);
        if (!pv) begin
          pv = 1'b1;
          held = {bus.d, bus.borrow, bus.ovf, bus.zero, bus.neg};
          wait_n = (hold_force >= 0) ? hold_force : int'($urandom_range(0, 2));
          hold_force = -1;
          if (sb_q.size() == 0) check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
          else check("latency", 32'(cyc - sb_q[0].acc), 32'd4);
        end else begin
          check("held_under_backpressure", 32'({bus.d, bus.borrow, bus.ovf, bus.zero, bus.neg}), 32'(held));
        end
        if (bus.out_ready || wait_n == 0) begin
          bus.out_ready = 1'b1;
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("d", 32'(bus.d), 32'(e.d));
            check("borrow", 32'(bus.borrow), 32'(e.borrow));
            check("ovf", 32'(bus.ovf), 32'(e.ovf));
            check("zero", 32'(bus.zero), 32'(e.zero));
            check("neg", 32'(bus.neg), 32'(e.neg));
          end
        end else begin
          wait_n--;
        end
      end
    end
  end

  // Driver: reset, directed vectors, backpressure, reset abort, random ops.
  initial begin : driver
    logic [15:0] corners [6];
    logic [15:0] ra, rb;
    corners[0] = 16'h0000; corners[1] = 16'hFFFF; corners[2] = 16'h8000;
    corners[3] = 16'h7FFF; corners[4] = 16'h0001; corners[5] = 16'h8001;
    bus.in_valid = 1'b0;
    bus.a = 16'h0000;
    bus.b = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_d", 32'(bus.d), 32'd0);
    check("rst_flags", 32'({bus.borrow, bus.ovf, bus.zero, bus.neg}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    issue(16'h0005, 16'h0003, 1'b1, 1'b1);
    issue(16'h0003, 16'h0005, 1'b1, 1'b1);
    issue(16'h8000, 16'h0001, 1'b1, 1'b1);
    issue(16'h7FFF, 16'hFFFF, 1'b1, 1'b1);
    issue(16'h1234, 16'h1234, 1'b1, 1'b1);
    issue(16'h0000, 16'h8000, 1'b1, 1'b1);
    drain();

    // Backpressure: hold out_ready low for 3 cycles while inputs churn,
    // then the next operation follows right after the IDLE bubble.
    hold_force = 3;
    @(negedge clk);
    issue(16'h5555, 16'h1234, 1'b1, 1'b1);
    issue(16'hFFFF, 16'h0001, 1'b1, 1'b1);
    drain();

    // Reset in the third RUN cycle: aborted operation must not produce output.
    issue(16'hAAAA, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd0);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_d", 32'(bus.d), 32'd0);
    check("abort_flags", 32'({bus.borrow, bus.ovf, bus.zero, bus.neg}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    issue(16'h0100, 16'h0001, 1'b1, 1'b1);
    drain();

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
      issue(ra, rb, 1'b1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
